// File: rtl/mips_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_mc_control_fsm
//   Main control unit for a multi-cycle MIPS datapath. It is a Moore FSM that
//   decodes op/funct from the instruction register and sequences each
//   instruction over 3 to 5 cycles. It drives the unified instruction/data
//   memory strobes, the IR/PC/register-file enables, and the ALU and mux
//   selects. It also keeps a count of retired instructions and a sticky flag
//   that records any illegal opcode or illegal funct.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   op, funct    instr[31:26] and instr[5:0] from the IR
//   zero         ALU zero flag, used for the beq compare
//   pc_en        PC write enable = pc_write | (branch & zero)
//   iord         memory address select: 0 = PC, 1 = ALUOut
//   mem_we       memory write enable (data half)
//   mem_re       memory read select: 0 = instruction half, 1 = data half
//   ir_write     instruction register load
//   reg_dst      register-file write address: 0 = rt, 1 = rd
//   mem_to_reg   register-file write data: 0 = ALUOut, 1 = MDR
//   reg_write    register-file write enable
//   alu_src_a    0 = PC, 1 = rs
//   alu_src_b    00 = rt, 01 = constant 1, 10/11 = SignImm
//   alu_ctrl     010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_src       00 = ALUResult, 01 = ALUOut, 10 = jump target
//   state        current state encoding (debug)
//   retired_cnt  instructions completed since reset (wraps)
//   illegal      sticky flag: unknown op or unknown R-type funct seen
// -----------------------------------------------------------------------------
module mips_mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_we,
  output logic             mem_re,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       op_ok;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       retire;
  logic       pc_write;
  logic       branch;
  logic       mem_we_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  // Opcode legality.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    op_ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      default:                                       op_ok = 1'b0;
    endcase
  end

  // R-type funct map; an unknown funct still executes, as an add.
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Next-state logic. Unused encodings 12-15 fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode: unlisted fields stay 0 in every state.
  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord          = 1'b0;
    mem_we_raw    = 1'b0;
    mem_re        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = 3'b000;
    pc_src        = 2'b00;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b01;
        alu_ctrl     = ALU_ADD;
        pc_write     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_re = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_re     = 1'b1;
        mem_we_raw = 1'b1;
        retire     = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces FETCH, whose own decode would raise ir_write and pc_en;
  // the enables are gated so nothing is written while rst is held.
  assign pc_en     = (pc_write | (branch & zero)) & ~rst;
  assign mem_we    = mem_we_raw & ~rst;
  assign ir_write  = ir_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign state     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      retired_cnt <= '0;
      illegal     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      state_q <= state_d;
      if (retire)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if ((state_q == S_DECODE && !op_ok) || (state_q == S_EXEC && !funct_ok))
        illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_control_fsm
//   Self-checking bench for mips_mc_control_fsm. A reference model describes
//   each instruction class as its list of visited states plus the control word
//   listed for each state, and tracks the retired count and sticky illegal flag
//   per instruction. A second instance with CNT_W=4 shares all inputs and is
//   used to observe counter wrap.
// -----------------------------------------------------------------------------
module tb_mips_mc_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_we;
    logic       mem_re;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;

  logic        pc_en, iord, mem_we, mem_re, ir_write, reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] retired_cnt;

  logic        s_pc_en, s_iord, s_mem_we, s_mem_re, s_ir_write, s_reg_dst;
  logic        s_mem_to_reg, s_reg_write, s_alu_src_a, s_illegal;
  logic [1:0]  s_alu_src_b, s_pc_src;
  logic [2:0]  s_alu_ctrl;
  logic [3:0]  s_state;
  logic [3:0]  s_retired_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_cnt = '0;
  logic        m_ill = 1'b0;

  always #5 clk = ~clk;

  mips_mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_we(mem_we), .mem_re(mem_re),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .state(state),
    .retired_cnt(retired_cnt), .illegal(illegal)
  );

  mips_mc_control_fsm #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_en(s_pc_en), .iord(s_iord), .mem_we(s_mem_we), .mem_re(s_mem_re),
    .ir_write(s_ir_write), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg),
    .reg_write(s_reg_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .alu_ctrl(s_alu_ctrl), .pc_src(s_pc_src), .state(s_state),
    .retired_cnt(s_retired_cnt), .illegal(s_illegal)
  );

  // ---------------------------------------------------------------- model ---
  function automatic bit funct_known(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // State path an instruction takes; an unknown op stops after DECODE.
  task automatic build_path(input logic [5:0] o, output int p[5], output int n,
                            output bit retires);
    p = '{0, 1, 0, 0, 0};
    retires = 1'b1;
    case (o)
      6'b100011: begin p = '{0, 1, 2, 3, 4};  n = 5; end
      6'b101011: begin p = '{0, 1, 2, 5, 0};  n = 4; end
      6'b000000: begin p = '{0, 1, 6, 7, 0};  n = 4; end
      6'b001000: begin p = '{0, 1, 9, 10, 0}; n = 4; end
      6'b000100: begin p = '{0, 1, 8, 0, 0};  n = 3; end
      6'b000010: begin p = '{0, 1, 11, 0, 0}; n = 3; end
      default:   begin n = 2; retires = 1'b0; end
    endcase
  endtask

  // Control word listed for each state (reset not asserted).
  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] f, input logic z);
    ctrl_t c = '0;
    case (st)
      0:  begin c.ir_write = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010; c.pc_en = 1; end
      1:  begin c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010; end
      3:  begin c.iord = 1; c.mem_re = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.iord = 1; c.mem_re = 1; c.mem_we = 1; end
      6:  begin c.alu_src_a = 1; c.alu_ctrl = funct_alu(f); end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_en = z; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010; end
      10: begin c.reg_write = 1; end
      11: begin c.pc_src = 2'b10; c.pc_en = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t act_ctrl();
    return '{pc_en, iord, mem_we, mem_re, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src};
  endfunction

  task automatic check_counters(input string tag);
    tests++;
    if (retired_cnt !== m_cnt) begin
      fails++;
      $display("FAIL %s retired_cnt: got %0d expected %0d", tag, retired_cnt, m_cnt);
    end
    tests++;
    if (s_retired_cnt !== m_cnt[3:0]) begin
      fails++;
      $display("FAIL %s small retired_cnt: got %0d expected %0d", tag, s_retired_cnt, m_cnt[3:0]);
    end
    tests++;
    if (illegal !== m_ill) begin
      fails++;
      $display("FAIL %s illegal: got %b expected %b", tag, illegal, m_ill);
    end
  endtask

  // Runs one instruction from FETCH, checking state and controls every cycle
  // with a fresh random zero, then the counters once it has completed.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input string tag);
    int  p[5];
    int  n;
    bit  retires;
    ctrl_t e;
    build_path(o, p, n, retires);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op = o;
      funct = f;
      zero = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if (state !== 4'(p[k]) || s_state !== 4'(p[k])) begin
        fails++;
        $display("FAIL %s step%0d state: got %0d/%0d expected %0d", tag, k, state, s_state, p[k]);
      end
      e = exp_ctrl(p[k], f, zero);
      tests++;
      if (act_ctrl() !== e) begin
        fails++;
        $display("FAIL %s step%0d ctrl (st %0d): got %h expected %h", tag, k, p[k], act_ctrl(), e);
      end
    end
    @(posedge clk);
    #1;
    if (retires) m_cnt = m_cnt + 1;
    if (!retires || (o == 6'b000000 && !funct_known(f))) m_ill = 1'b1;
    check_counters(tag);
  endtask

  // ---------------------------------------------------------------- tests ---
  task automatic test_reset();
    ctrl_t e;
    e = exp_ctrl(0, 6'd0, 1'b0);
    e.ir_write = 1'b0;
    e.pc_en = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op = 6'($urandom);
      zero = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if (state !== 4'd0) begin
        fails++;
        $display("FAIL reset state: got %0d expected 0", state);
      end
      tests++;
      if (act_ctrl() !== e) begin
        fails++;
        $display("FAIL reset ctrl: got %h expected %h", act_ctrl(), e);
      end
      check_counters("reset");
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'($urandom), "lw");
  endtask

  task automatic test_sw_add();
    run_instr(6'b101011, 6'($urandom), "sw");
    run_instr(6'b000000, 6'b100000, "add");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'($urandom), "beq_a");
    run_instr(6'b000100, 6'($urandom), "beq_b");
    run_instr(6'b000100, 6'($urandom), "beq_c");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b000000, "bad_op");
    run_instr(6'b000010, 6'b000000, "j_after_bad");
    run_instr(6'b000000, 6'b000111, "bad_funct");
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b001000, 6'b000010, 6'b000000};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, f;
    for (int i = 0; i < 80; i++) begin
      int r = int'($urandom_range(0, 7));
      o = (r == 7) ? 6'($urandom) : ops[r];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(o, f, "rand");
    end
  endtask

  task automatic test_rst_mid_exec();
    @(negedge clk);
    op = 6'b000000;
    funct = 6'b100010;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (state !== 4'd6) begin
      fails++;
      $display("FAIL rst_mid setup state: got %0d expected 6", state);
    end
    #1 rst = 1'b1;
    #1;
    m_cnt = '0;
    m_ill = 1'b0;
    tests++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL rst_mid async state: got %0d expected 0", state);
    end
    check_counters("rst_mid");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (reg_write !== 1'b0 || ir_write !== 1'b0 || pc_en !== 1'b0 || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid enables: got rw=%b ir=%b pc=%b we=%b expected all 0",
                 reg_write, ir_write, pc_en, mem_we);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) run_instr(6'b000010, 6'($urandom), "j_wrap");
    tests++;
    if (s_retired_cnt !== 4'd0 || retired_cnt !== 32'd16) begin
      fails++;
      $display("FAIL wrap: got small=%0d wide=%0d expected small=0 wide=16",
               s_retired_cnt, retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_add();
    test_beq();
    test_illegal();
    test_random();
    test_rst_mid_exec();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
